// File: rtl/irq_controller.sv
// Interrupt arbitration: edge-detects platform requests, masks them with mie,
// raises a one-cycle trap for the lowest eligible line and acknowledges it on mret.
module irq_controller #(
    parameter int unsigned NUM_IRQ = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    input  logic               exception_i,
    input  logic               mret_i,
    input  logic               stall_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [NUM_IRQ-1:0] irq_ret_o
);

    localparam int unsigned IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int unsigned CAUSE_BASE = 32'h8000_0010;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] req_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [NUM_IRQ-1:0] edge_c;
    logic [NUM_IRQ-1:0] elig_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               take_c;
    logic               ret_c;
    logic               unused_mie_c;

    // Only mie[16 +: NUM_IRQ] matter; the rest of the CSR is deliberately ignored.
    assign unused_mie_c = ^mie_i;

    assign edge_c = irq_req_i & ~req_q;
    assign elig_c = pend_q & mie_i[16 +: NUM_IRQ];

    // Lowest eligible index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        win_idx_c = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig_c[i]) begin
                win_idx_c = IDX_W'(i);
            end
        end
    end

    assign take_c = (state_q == IDLE) && (|elig_c) && !exception_i && !stall_i;
    assign ret_c  = (state_q == BUSY) && mret_i && !stall_i;

    // Outputs are combinational so the CSR controller sees them in the taking cycle.
    always_comb begin
        irq_o       = take_c;
        irq_cause_o = '0;
        irq_ret_o   = '0;
        if (take_c) begin
            irq_cause_o = CAUSE_BASE + 32'(win_idx_c);
        end
        if (ret_c) begin
            irq_ret_o = NUM_IRQ'(1) << idx_q;
        end
    end

    // Next-state: a new edge on the acknowledged line re-arms it (set wins).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = (pend_q & ~irq_ret_o) | edge_c;
        unique case (state_q)
            IDLE: begin
                if (take_c) begin
                    state_d = BUSY;
                    idx_d   = win_idx_c;
                end
            end
            BUSY: begin
                if (ret_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= irq_req_i;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: take/return, priority, masking, deferral,
// busy handling and asynchronous reset in the middle of a handler.
module tb_irq_controller;

    localparam int unsigned NUM_IRQ = 16;

    logic               clk_i;
    logic               rst_i;
    logic [NUM_IRQ-1:0] irq_req_i;
    logic [31:0]        mie_i;
    logic               exception_i;
    logic               mret_i;
    logic               stall_i;
    logic               irq_o;
    logic [31:0]        irq_cause_o;
    logic [NUM_IRQ-1:0] irq_ret_o;

    int total = 0;
    int bad   = 0;

    irq_controller #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .irq_req_i   (irq_req_i),
        .mie_i       (mie_i),
        .exception_i (exception_i),
        .mret_i      (mret_i),
        .stall_i     (stall_i),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_trap(input string tag, input logic [31:0] cause);
        chk({tag, "_irq"}, 32'(irq_o), 32'd1);
        chk({tag, "_cause"}, irq_cause_o, cause);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_irq"}, 32'(irq_o), 32'd0);
        chk({tag, "_cause"}, irq_cause_o, 32'd0);
    endtask

    initial begin
        rst_i       = 1'b0;
        irq_req_i   = '0;
        mie_i       = '0;
        exception_i = 1'b0;
        mret_i      = 1'b0;
        stall_i     = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset_ret", 32'(irq_ret_o), 32'd0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();

        // Basic take/return on line 0
        mie_i        = 32'h0001_0000;
        irq_req_i[0] = 1'b1;
        #1 chk_quiet("basic_pre");
        tick();
        irq_req_i = '0;
        #1 chk_trap("basic_take", 32'h8000_0010);
        tick();
        chk_quiet("basic_busy");
        mret_i = 1'b1;
        #1 chk("basic_ret", 32'(irq_ret_o), 32'h0001);
        tick();
        mret_i = 1'b0;
        #1 chk_quiet("basic_after");
        chk("basic_after_ret", 32'(irq_ret_o), 32'd0);

        // Priority: lines 3 and 5 together
        mie_i     = 32'hFFFF_0000;
        irq_req_i = NUM_IRQ'(16'h0028);
        tick();
        irq_req_i = '0;
        #1 chk_trap("prio_first", 32'h8000_0013);
        tick();
        chk_quiet("prio_busy");
        mret_i = 1'b1;
        #1 chk("prio_ret3", 32'(irq_ret_o), 32'h0008);
        tick();
        mret_i = 1'b0;
        #1 chk_trap("prio_second", 32'h8000_0015);
        tick();
        mret_i = 1'b1;
        #1 chk("prio_ret5", 32'(irq_ret_o), 32'h0020);
        tick();
        mret_i = 1'b0;
        #1 chk_quiet("prio_empty");

        // Masking: line 2 waits until mie[18] is set
        mie_i        = 32'h0;
        irq_req_i[2] = 1'b1;
        tick();
        irq_req_i = '0;
        for (int i = 0; i < 10; i++) begin
            #1 chk("mask_hold_irq", 32'(irq_o), 32'd0);
            tick();
        end
        mie_i = 32'h0004_0000;
        #1 chk_trap("mask_release", 32'h8000_0012);
        tick();
        mret_i = 1'b1;
        #1 chk("mask_ret", 32'(irq_ret_o), 32'h0004);
        tick();
        mret_i = 1'b0;

        // Deferral: exception for 2 cycles, then stall for 1
        mie_i        = 32'hFFFF_0000;
        exception_i  = 1'b1;
        irq_req_i[6] = 1'b1;
        tick();
        irq_req_i = '0;
        #1 chk_quiet("defer_exc1");
        tick();
        chk_quiet("defer_exc2");
        exception_i = 1'b0;
        stall_i     = 1'b1;
        #1 chk_quiet("defer_stall");
        tick();
        stall_i = 1'b0;
        #1 chk_trap("defer_fire", 32'h8000_0016);
        tick();
        mret_i = 1'b1;
        #1 chk("defer_ret", 32'(irq_ret_o), 32'h0040);
        tick();
        mret_i = 1'b0;

        // Busy handling: line 4 in service, line 1 arrives
        irq_req_i[4] = 1'b1;
        tick();
        irq_req_i = '0;
        #1 chk_trap("busy_take4", 32'h8000_0014);
        tick();
        irq_req_i[1] = 1'b1;
        #1 chk_quiet("busy_edge1");
        tick();
        irq_req_i = '0;
        #1 chk_quiet("busy_pend1");
        mret_i  = 1'b1;
        stall_i = 1'b1;
        #1 chk("busy_stalled_mret", 32'(irq_ret_o), 32'd0);
        tick();
        stall_i = 1'b0;
        #1 chk("busy_ret4", 32'(irq_ret_o), 32'h0010);
        tick();
        mret_i = 1'b0;
        #1 chk_trap("busy_take1", 32'h8000_0011);
        tick();
        mret_i = 1'b1;
        #1 chk("busy_ret1", 32'(irq_ret_o), 32'h0002);
        tick();
        #1 chk("idle_mret_ret", 32'(irq_ret_o), 32'd0);
        chk_quiet("idle_mret");
        tick();
        mret_i = 1'b0;

        // A held request fires only once
        irq_req_i[9] = 1'b1;
        tick();
        #1 chk_trap("held_take", 32'h8000_0019);
        tick();
        mret_i = 1'b1;
        #1 chk("held_ret", 32'(irq_ret_o), 32'h0200);
        tick();
        mret_i = 1'b0;
        #1 chk_quiet("held_no_retrigger");
        tick();
        irq_req_i = '0;

        // Reset while busy on line 0 with line 7 pending
        irq_req_i[0] = 1'b1;
        tick();
        irq_req_i = '0;
        #1 chk_trap("rst_take0", 32'h8000_0010);
        tick();
        irq_req_i[7] = 1'b1;
        tick();
        irq_req_i = '0;
        mret_i    = 1'b1;
        #1 chk("rst_pre_ret", 32'(irq_ret_o), 32'h0001);
        rst_i = 1'b0;
        #1 chk_quiet("rst_async");
        chk("rst_async_ret", 32'(irq_ret_o), 32'd0);
        mret_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rst_no_trap", 32'(irq_o), 32'd0);
            tick();
        end
        irq_req_i[7] = 1'b1;
        tick();
        irq_req_i = '0;
        #1 chk_trap("rst_fresh7", 32'h8000_0017);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
